// File: rtl/clock_div_pkg.sv
// ---------------------------------------------------------------------------
// clock_div_pkg
// Shared definitions for the programmable clock divider:
//   MIN_DIV     smallest divisor the divider can produce a clock for
//   half_div()  high-phase length in whole clk cycles (N >> 1)
//   cfg_state_t config-port state: idle (ready) or holding a pending divisor
// ---------------------------------------------------------------------------
package clock_div_pkg;

    localparam int MIN_DIV = 2;

    typedef enum logic {
        CFG_IDLE = 1'b0,
        CFG_PEND = 1'b1
    } cfg_state_t;

    function automatic logic [31:0] half_div(input logic [31:0] n);
        return n >> 1;
    endfunction

endpackage

// File: rtl/clock_div_core.sv
// ---------------------------------------------------------------------------
// clock_div_core
// Period counter and phase generator for a 50% duty-cycle divided clock.
// Optional feature: define CLKDIV_TICK_EN to add the o_tick output.
// Ports:
//   clk        in   source clock (both edges used)
//   rst        in   asynchronous, active-high reset
//   i_div      in   divisor currently in effect (N >= 2)
//   i_apply    in   a new divisor takes effect on this edge; restart the count
//   o_wrap     out  counter is at N-1; this edge ends the current period
//   o_clk_out  out  divided clock
//   o_tick     out  (CLKDIV_TICK_EN) high during the cycle when cnt == 1
// ---------------------------------------------------------------------------
module clock_div_core
    import clock_div_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] i_div,
    input  logic             i_apply,
    output logic             o_wrap,
    output logic             o_clk_out
`ifdef CLKDIV_TICK_EN
    ,
    output logic             o_tick
`endif
);

    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] w_cnt_next;
    logic [DIV_W-1:0] w_half;
    logic             w_wrap;
    logic             r_pos_q;
    logic             r_neg_q;

    assign w_half     = DIV_W'(half_div(32'(i_div)));
    assign w_wrap     = (r_cnt == (i_div - ONE));
    assign w_cnt_next = (w_wrap || i_apply) ? '0 : r_cnt + ONE;
    assign o_wrap     = w_wrap;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values and simulation matches the hardware.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_pos_q <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_next;
            // High for the H cycles that follow the count reaching 1, so the
            // rising edge of clk_out always coincides with cnt becoming 1.
            r_pos_q <= (w_cnt_next != '0) && (w_cnt_next <= w_half);
        end
    end

    // For odd N the half-cycle extension comes from a negedge copy of the
    // posedge phase; OR-ing them stretches the high time by exactly 0.5 clk.
    // The negedge copy only rises while pos_q is already high and only falls
    // after pos_q has fallen, so the OR cannot glitch.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            r_neg_q <= 1'b0;
        end else begin
            r_neg_q <= r_pos_q & i_div[0];
        end
    end

    assign o_clk_out = r_pos_q | r_neg_q;

`ifdef CLKDIV_TICK_EN
    assign o_tick = (r_cnt == ONE);
`endif

endmodule

// File: rtl/clock_divider_prog.sv
// ---------------------------------------------------------------------------
// clock_divider_prog
// Runtime-programmable integer clock divider, 50% duty for even and odd N.
// A new divisor is taken through a valid/ready port and applied only at a
// period boundary, so the output never shows a runt or stretched pulse.
// Optional feature: define CLKDIV_TICK_EN to add the tick output.
// Ports:
//   clk         in   source clock
//   rst         in   asynchronous, active-high reset
//   div_valid   in   new divisor offered
//   div_data    in   requested divisor N
//   div_ready   out  can accept a divisor; low while an update is pending
//   cfg_err     out  1-cycle pulse: accepted divisor was 0 or 1, discarded
//   div_active  out  divisor currently in effect
//   clk_out     out  divided clock
//   tick        out  (CLKDIV_TICK_EN) 1-cycle pulse aligned with clk_out rise
// ---------------------------------------------------------------------------
module clock_divider_prog
    import clock_div_pkg::*;
#(
    parameter int DIV_W       = 8,
    parameter int DIV_DEFAULT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_valid,
    input  logic [DIV_W-1:0] div_data,
    output logic             div_ready,
    output logic             cfg_err,
    output logic [DIV_W-1:0] div_active,
    output logic             clk_out
`ifdef CLKDIV_TICK_EN
    ,
    output logic             tick
`endif
);

    cfg_state_t       r_state;
    cfg_state_t       w_state_next;
    logic [DIV_W-1:0] r_pending;
    logic [DIV_W-1:0] r_div_active;
    logic             r_cfg_err;
    logic             w_wrap;
    logic             w_accept;
    logic             w_bad;
    logic             w_load;
    logic             w_apply;
    logic             w_err_next;

    // NOTE: every signal driven here gets a default first, so no branch can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_apply      = 1'b0;
        w_err_next   = 1'b0;
        div_ready    = (r_state == CFG_IDLE);
        w_accept     = div_valid && (r_state == CFG_IDLE);
        w_bad        = (div_data < DIV_W'(MIN_DIV));

        case (r_state)
            CFG_IDLE: begin
                if (w_accept) begin
                    if (w_bad) begin
                        w_err_next = 1'b1;
                    end else begin
                        w_load       = 1'b1;
                        w_state_next = CFG_PEND;
                    end
                end
            end
            CFG_PEND: begin
                // Only the period-ending edge may switch N; the running
                // period always completes at the old divisor.
                if (w_wrap) begin
                    w_apply      = 1'b1;
                    w_state_next = CFG_IDLE;
                end
            end
            default: begin
                w_state_next = CFG_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= CFG_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending    <= '0;
            r_div_active <= DIV_W'(DIV_DEFAULT);
            r_cfg_err    <= 1'b0;
        end else begin
            r_cfg_err <= w_err_next;
            if (w_load) begin
                r_pending <= div_data;
            end
            if (w_apply) begin
                r_div_active <= r_pending;
            end
        end
    end

    assign cfg_err    = r_cfg_err;
    assign div_active = r_div_active;

    clock_div_core #(
        .DIV_W (DIV_W)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .i_div     (r_div_active),
        .i_apply   (w_apply),
        .o_wrap    (w_wrap),
        .o_clk_out (clk_out)
`ifdef CLKDIV_TICK_EN
        ,
        .o_tick    (tick)
`endif
    );

endmodule
